// File: rtl/koa_seq.sv
// ---------------------------------------------------------------------------
// koa_seq
// Sequencer that shares one external Karatsuba-Ofman (KOA) multiplier between
// two requesters. It picks a requester with round-robin arbitration, latches
// that requester's operand pair into registers that feed the multiplier, waits
// for the multiplier's combinational path to settle, pulses the multiplier's
// result-register load, and then presents the product on a valid/ready
// response channel tagged with the requester id.
//
// Parameters
//   SW   operand width of the shared multiplier
//   LAT  cycles from stable operands to a valid multiplier result (>= 1)
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   req0_valid_i/req0_ready_o requester 0 handshake, operands req0_a_i/req0_b_i
//   req1_valid_i/req1_ready_o requester 1 handshake, operands req1_a_i/req1_b_i
//   mult_a_o, mult_b_o        registered operands to the multiplier
//   mult_load_o               multiplier result-register load strobe
//   mult_result_i             multiplier product
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_id_o                  requester that owns the response (0 or 1)
//   rsp_data_o                product
//   busy_o                    high whenever an operation is in flight
// ---------------------------------------------------------------------------
module koa_seq #(
  parameter int SW  = 24,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  input  logic            req1_valid_i,
  output logic            req0_ready_o,
  output logic            req1_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic [SW-1:0]   mult_a_o,
  output logic [SW-1:0]   mult_b_o,
  output logic            mult_load_o,
  input  logic [2*SW-1:0] mult_result_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [2*SW-1:0] rsp_data_o,
  output logic            busy_o
);

  // The wait counter only ever holds values up to LAT-1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;
  logic          rsp_id;
  logic          grant;
  logic          accept;

  // Round-robin pick: a lone requester always wins; on a tie the requester
  // that was not served last wins. The pointer itself only moves on accept,
  // so a requester dropping valid while not granted changes nothing.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  // Requests are only taken in IDLE, so the cycle that completes a response
  // handshake can never also accept; the next accept is one cycle later.
  assign accept       = (state == IDLE) && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = (state == IDLE) && req0_valid_i && !grant;
  assign req1_ready_o = (state == IDLE) && req1_valid_i &&  grant;

  // The multiplier result register holds its value from LOAD onward, so the
  // response data is taken straight from it.
  assign rsp_data_o = mult_result_i;
  assign rsp_id_o   = rsp_id;

  // Sequencer FSM. mult_load_o, rsp_valid_o and busy_o are registered and are
  // set on the transition into the state that owns them, so they line up
  // exactly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_grant  <= 1'b1;
      rsp_id      <= 1'b0;
      mult_a_o    <= '0;
      mult_b_o    <= '0;
      mult_load_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rsp_id     <= grant;
            last_grant <= grant;
            mult_a_o   <= grant ? req1_a_i : req0_a_i;
            mult_b_o   <= grant ? req1_b_i : req0_b_i;
            busy_o     <= 1'b1;
            // With a single-cycle multiplier there is nothing to wait for.
            if (LAT == 1) begin
              state       <= LOAD;
              mult_load_o <= 1'b1;
              wait_cnt    <= '0;
            end else begin
              state    <= WAIT;
              wait_cnt <= CW'(LAT - 1);
            end
          end
        end

        WAIT: begin
          // The counter enters at LAT-1, so exiting at 1 gives LAT-1 cycles.
          if (wait_cnt <= CW'(1)) begin
            state       <= LOAD;
            mult_load_o <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        LOAD: begin
          state       <= RESP;
          mult_load_o <= 1'b0;
          rsp_valid_o <= 1'b1;
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          mult_load_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_koa_seq.sv
// ---------------------------------------------------------------------------
// tb_koa_seq
// Self-checking bench for koa_seq. A LAT=2 instance carries most scenarios;
// a second LAT=1 instance covers the single-cycle multiplier build. Each
// external multiplier is modelled as a result register loaded with a*b on
// its load strobe. Expected behaviour comes from a transaction-level model
// (who should be granted, when the response is due, what the product is).
// ---------------------------------------------------------------------------
module tb_koa_seq;

  localparam int SW  = 24;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [SW-1:0]   req0_a, req0_b, req1_a, req1_b, mult_a, mult_b;
  logic            mult_load;
  logic [2*SW-1:0] mult_result = '0;
  logic            rsp_valid, rsp_ready, rsp_id, busy;
  logic [2*SW-1:0] rsp_data;

  logic            l1_req0_valid, l1_req1_valid, l1_req0_ready, l1_req1_ready;
  logic [SW-1:0]   l1_req0_a, l1_req0_b, l1_req1_a, l1_req1_b, l1_mult_a, l1_mult_b;
  logic            l1_mult_load;
  logic [2*SW-1:0] l1_mult_result = '0;
  logic            l1_rsp_valid, l1_rsp_ready, l1_rsp_id, l1_busy;
  logic [2*SW-1:0] l1_rsp_data;

  int tests_run    = 0;
  int tests_failed = 0;

  // Last-granted requester as seen by the model; 1 out of reset.
  bit tb_last = 1'b1;

  koa_seq #(.SW(SW), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_load_o(mult_load),
    .mult_result_i(mult_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .busy_o(busy)
  );

  koa_seq #(.SW(SW), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0_valid_i(l1_req0_valid), .req1_valid_i(l1_req1_valid),
    .req0_ready_o(l1_req0_ready), .req1_ready_o(l1_req1_ready),
    .req0_a_i(l1_req0_a), .req0_b_i(l1_req0_b), .req1_a_i(l1_req1_a), .req1_b_i(l1_req1_b),
    .mult_a_o(l1_mult_a), .mult_b_o(l1_mult_b), .mult_load_o(l1_mult_load),
    .mult_result_i(l1_mult_result),
    .rsp_valid_o(l1_rsp_valid), .rsp_ready_i(l1_rsp_ready), .rsp_id_o(l1_rsp_id),
    .rsp_data_o(l1_rsp_data), .busy_o(l1_busy)
  );

  // External multipliers: result register captures the product on load.
  always @(posedge clk) begin
    if (mult_load)    mult_result    <= (2*SW)'(mult_a) * (2*SW)'(mult_b);
    if (l1_mult_load) l1_mult_result <= (2*SW)'(l1_mult_a) * (2*SW)'(l1_mult_b);
  end

  function automatic logic [2*SW-1:0] prod(input logic [SW-1:0] a, input logic [SW-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*SW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tb_last = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || mult_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got valid=%b busy=%b load=%b expected 0 0 0", rsp_valid, busy, mult_load);
    end
    tests_run++;
    if (mult_a !== '0 || mult_b !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_operands got a=%h b=%h expected 0 0", mult_a, mult_b);
    end
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    req0_a = 24'd3; req0_b = 24'd5; req0_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_ready got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    tb_last = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || mult_load !== 1'b0 || rsp_valid !== 1'b0 || mult_a !== 24'd3 || mult_b !== 24'd5) begin
      tests_failed++;
      $display("[TB] FAIL single_cycle1 got busy=%b load=%b valid=%b a=%0d b=%0d expected 1 0 0 3 5",
               busy, mult_load, rsp_valid, mult_a, mult_b);
    end
    tick();
    tests_run++;
    if (mult_load !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_load got load=%b valid=%b expected 1 0", mult_load, rsp_valid);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 48'd15 || mult_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_rsp got valid=%b id=%b data=%0d load=%b expected 1 0 15 0",
               rsp_valid, rsp_id, rsp_data, mult_load);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_done got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_tie();
    logic            exp_id   [2];
    logic [2*SW-1:0] exp_data [2];
    int              cnt;
    exp_id[0] = 1'b0; exp_data[0] = 48'd42;
    exp_id[1] = 1'b1; exp_data[1] = 48'hFFFFFE000001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tb_last = 1'b1;
    req0_a = 24'd7; req0_b = 24'd6;
    req1_a = 24'hFFFFFF; req1_b = 24'hFFFFFF;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tie_first_grant got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    for (int n = 0; n < 2; n++) begin
      cnt = 0;
      while (rsp_valid !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      if (n == 1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tests_run++;
      if (cnt >= 20) begin
        tests_failed++;
        $display("[TB] FAIL tie_timeout rsp %0d got no response expected one within 20 cycles", n);
      end else if (rsp_id !== exp_id[n] || rsp_data !== exp_data[n]) begin
        tests_failed++;
        $display("[TB] FAIL tie_rsp%0d got id=%b data=%h expected id=%b data=%h",
                 n, rsp_id, rsp_data, exp_id[n], exp_data[n]);
      end
      tick();
    end
    rsp_ready = 1'b0;
    tb_last = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [SW-1:0]   a, b;
    logic [2*SW-1:0] exp_data;
    int              cnt;
    a = SW'($urandom()); b = SW'($urandom());
    exp_data = prod(a, b);
    req1_a = a; req1_b = b; req1_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    tb_last = 1'b1;
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    tests_run++;
    if (cnt >= 20) begin
      tests_failed++;
      $display("[TB] FAIL bp_timeout got no response expected one within 20 cycles");
    end
    // Offer new work from both sides while the response is stalled.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== 1'b1 || mult_a !== a || mult_b !== b) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold cycle %0d got valid=%b id=%b data=%h a=%h expected 1 1 %h %h",
                 i, rsp_valid, rsp_id, rsp_data, mult_a, exp_data, a);
      end
      tests_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL bp_ready cycle %0d got r0=%b r1=%b busy=%b expected 0 0 1",
                 i, req0_ready, req1_ready, busy);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_release got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  // Cycle-by-cycle traffic against the transaction model. In fair mode both
  // requesters stay valid and responses are taken at once; otherwise valid
  // and rsp_ready are random.
  task automatic run_traffic(input int n_txn, input bit random_mode);
    bit              m_busy, g, exp_r0, exp_r1, exp_load, exp_rv;
    int              acc_cyc, hs_cyc, done, acc_count, cyc, limit;
    logic [SW-1:0]   ea, eb;
    logic            eid;
    logic [2*SW-1:0] edata;
    m_busy = 1'b0; acc_cyc = 0; hs_cyc = -10; done = 0; acc_count = 0; cyc = 0;
    ea = '0; eb = '0; eid = 1'b0; edata = '0;
    limit = n_txn * 40 + 20;
    while (done < n_txn && cyc < limit) begin
      if (random_mode) begin
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        rsp_ready  = 1'($urandom_range(0, 1));
      end else begin
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      end
      req0_a = SW'($urandom()); req0_b = SW'($urandom());
      req1_a = SW'($urandom()); req1_b = SW'($urandom());
      #1;
      exp_r0 = 1'b0; exp_r1 = 1'b0; g = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        g = (req0_valid && req1_valid) ? ~tb_last : req1_valid;
        exp_r0 = ~g; exp_r1 = g;
      end
      exp_load = m_busy && (cyc == acc_cyc + LAT);
      exp_rv   = m_busy && (cyc >= acc_cyc + LAT + 1);
      tests_run++;
      if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin
        tests_failed++;
        $display("[TB] FAIL traffic_ready cyc %0d got r0=%b r1=%b expected %b %b",
                 cyc, req0_ready, req1_ready, exp_r0, exp_r1);
      end
      tests_run++;
      if (mult_load !== exp_load || rsp_valid !== exp_rv || busy !== m_busy) begin
        tests_failed++;
        $display("[TB] FAIL traffic_ctrl cyc %0d got load=%b valid=%b busy=%b expected %b %b %b",
                 cyc, mult_load, rsp_valid, busy, exp_load, exp_rv, m_busy);
      end
      if (m_busy) begin
        tests_run++;
        if (mult_a !== ea || mult_b !== eb) begin
          tests_failed++;
          $display("[TB] FAIL traffic_operands cyc %0d got a=%h b=%h expected %h %h", cyc, mult_a, mult_b, ea, eb);
        end
      end
      if (exp_rv && rsp_ready) begin
        tests_run++;
        if (rsp_id !== eid || rsp_data !== edata) begin
          tests_failed++;
          $display("[TB] FAIL traffic_rsp cyc %0d got id=%b data=%h expected %b %h", cyc, rsp_id, rsp_data, eid, edata);
        end
        done++;
        hs_cyc = cyc;
        m_busy = 1'b0;
      end else if (exp_r0 || exp_r1) begin
        if (!random_mode && acc_count > 0) begin
          tests_run++;
          if (cyc != hs_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL fair_gap got accept %0d cycles after handshake expected 1", cyc - hs_cyc);
          end
        end
        acc_count++;
        m_busy  = 1'b1;
        acc_cyc = cyc;
        eid     = g;
        ea      = g ? req1_a : req0_a;
        eb      = g ? req1_b : req0_b;
        edata   = prod(ea, eb);
        tb_last = g;
      end
      tick();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tests_run++;
    if (done < n_txn) begin
      tests_failed++;
      $display("[TB] FAIL traffic_timeout got %0d responses expected %0d", done, n_txn);
    end
  endtask

  task automatic test_fairness();
    run_traffic(6, 1'b0);
  endtask

  task automatic test_random();
    run_traffic(30, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    req0_a = SW'($urandom()); req0_b = SW'($urandom()); req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tb_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (mult_load !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || mult_a !== '0) begin
        tests_failed++;
        $display("[TB] FAIL rstwait_quiet cycle %0d got load=%b valid=%b busy=%b a=%h expected 0 0 0 0",
                 i, mult_load, rsp_valid, busy, mult_a);
      end
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_tie got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_lat1();
    logic [SW-1:0] a, b;
    a = SW'($urandom()); b = SW'($urandom());
    l1_req1_a = a; l1_req1_b = b; l1_req1_valid = 1'b1;
    #1;
    tests_run++;
    if (l1_req1_ready !== 1'b1 || l1_req0_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lat1_ready got r0=%b r1=%b expected 0 1", l1_req0_ready, l1_req1_ready);
    end
    tick();
    l1_req1_valid = 1'b0;
    tests_run++;
    if (l1_mult_load !== 1'b1 || l1_rsp_valid !== 1'b0 || l1_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lat1_load got load=%b valid=%b busy=%b expected 1 0 1", l1_mult_load, l1_rsp_valid, l1_busy);
    end
    tick();
    tests_run++;
    if (l1_rsp_valid !== 1'b1 || l1_rsp_id !== 1'b1 || l1_rsp_data !== prod(a, b) || l1_mult_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lat1_rsp got valid=%b id=%b data=%h load=%b expected 1 1 %h 0",
               l1_rsp_valid, l1_rsp_id, l1_rsp_data, l1_mult_load, prod(a, b));
    end
    l1_rsp_ready = 1'b1;
    tick();
    l1_rsp_ready = 1'b0;
    tests_run++;
    if (l1_rsp_valid !== 1'b0 || l1_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lat1_done got valid=%b busy=%b expected 0 0", l1_rsp_valid, l1_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    l1_req0_valid = 1'b0; l1_req1_valid = 1'b0; l1_rsp_ready = 1'b0;
    l1_req0_a = '0; l1_req0_b = '0; l1_req1_a = '0; l1_req1_b = '0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_fairness();
    test_reset_in_wait();
    test_lat1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/koa_seq.md
KOA_SEQ -- requirements
Module: koa_seq

Interface
REQ-001 SHALL have parameter SW, default 24: operand width of the shared KOA multiplier.
REQ-002 SHALL have parameter LAT, default 2: cycles from operands stable to multiplier Result valid before its result register; LAT >= 1.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid_i  in  1 and req1_valid_i  in  1: requester operand pair valid.
REQ-006 SHALL have ports req0_ready_o  out  1 and req1_ready_o  out  1: request accepted when valid & ready.
REQ-007 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  in  SW: operands.
REQ-008 SHALL have ports mult_a_o, mult_b_o  out  SW: registered operands to multiplier Data_A_i / Data_B_i.
REQ-009 SHALL have port mult_load_o  out  1: drives multiplier load_b_i (result register load).
REQ-010 SHALL have port mult_result_i  in  2*SW: multiplier sgf_result_o.
REQ-011 SHALL have ports rsp_valid_o  out  1, rsp_ready_i  in  1, rsp_id_o  out  1 (0 = req0, 1 = req1), rsp_data_o  out  2*SW.
REQ-012 SHALL have port busy_o  out  1: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, LOAD, RESP.
REQ-014 IDLE: ready_o SHALL be asserted only toward the granted requester, and only when that requester's valid_i is high; on accept: latch operands into mult_a_o/mult_b_o, latch id, go to WAIT.
REQ-015 Arbitration SHALL be round-robin: if only one valid, grant it; if both valid, grant the requester not granted last; the last-grant pointer resets to 1, so req0 wins the first tie.
REQ-016 WAIT SHALL last LAT-1 cycles, counted by a down-counter loaded at accept; when LAT = 1, WAIT is skipped and the FSM enters LOAD directly.
REQ-017 LOAD SHALL last exactly one cycle with mult_load_o = 1; mult_load_o SHALL be 0 in every other state.
REQ-018 RESP SHALL assert rsp_valid_o; rsp_data_o = mult_result_i, rsp_id_o = latched id; hold all until rsp_ready_i = 1, then go to IDLE.
REQ-019 rsp_valid_o SHALL rise LAT+1 cycles after the accept cycle (accept cycle = cycle 0).
REQ-020 mult_a_o, mult_b_o SHALL remain stable from the cycle after accept through the last RESP cycle.
REQ-021 In IDLE, mult_a_o and mult_b_o SHALL retain their last values.
REQ-022 No new request SHALL be accepted in the cycle the response handshake completes; the earliest next accept is the following IDLE cycle.
REQ-023 rsp_valid_o SHALL NOT be dropped while rsp_ready_i = 0; rsp_ready_i SHALL be ignored outside RESP.
REQ-024 A requester deasserting valid_i while not granted SHALL NOT affect the FSM; the pointer updates only on accept.

Reset
REQ-025 With rst = 1 at a clock edge: state = IDLE, counter = 0, last-grant = 1, id = 0, mult_a_o = mult_b_o = 0.
REQ-026 After reset: mult_load_o = 0, rsp_valid_o = 0, busy_o = 0, both ready_o = 0 until a valid_i is seen in IDLE.
REQ-027 Reset in any state, including mid-WAIT or RESP, SHALL discard the operation in flight; no response is issued.

Verification
REQ-028 Single request: SW=24, LAT=2, req0 a=3, b=5 accepted at cycle 0 -> mult_load_o = 1 at cycle 2; rsp_valid_o = 1, id = 0, data = 15 at cycle 3.
REQ-029 Tie: both valid from reset, req0 a=7 b=6, req1 a=0xFFFFFF b=0xFFFFFF, rsp_ready_i = 1 -> first rsp id 0 data 42; second rsp id 1 data 0xFFFFFE000001.
REQ-030 Back-pressure: rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o, rsp_data_o, mult_a_o constant; both ready_o = 0; busy_o = 1.
REQ-031 Fairness: req0 and req1 continuously valid over 6 transactions -> grant order 0,1,0,1,0,1; each accept exactly one cycle after the previous response handshake.
REQ-032 Reset in WAIT: rst pulsed at cycle 1 after accept -> no mult_load_o, no rsp_valid_o; next tie grants req0.
REQ-033 LAT=1 build: accept at cycle 0 -> mult_load_o at cycle 1, rsp_valid_o at cycle 2.
